// File: rtl/sram_arb_pkg.sv
// Shared types for the instruction/data SRAM arbiter.
// Port ids double as grant-vector bit positions.
package sram_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {
    PORT_INST = 1'b0,
    PORT_DATA = 1'b1
  } port_e;

  typedef struct packed {
    logic              wr;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin arbiter with one-hot grant.
// A tie goes to the requester that did not win last.
module arb_rr2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  port_e last_grant;

  // Remember the winner; reset favours INST on the first tie.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant <= PORT_DATA;
    end else if (advance) begin
      last_grant <= port_e'(grant[1]);
    end
  end

  // Lone requester wins outright; a tie goes to the other port.
  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (&req): begin
        grant = (last_grant == PORT_DATA) ? 2'b01 : 2'b10;
      end
      default: begin
        grant = req;
      end
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one read-first registered SRAM between the fetch
// and data ports, one grant per cycle, response one cycle later.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int LEN_ADDR = ADDR_W,
  parameter int LEN_DATA = DATA_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  inst_req,
  input  logic                  inst_wr,
  input  logic [LEN_DATA/8-1:0] inst_wstrb,
  input  logic [LEN_ADDR-1:0]   inst_addr,
  input  logic [LEN_DATA-1:0]   inst_wdata,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  output logic [LEN_DATA-1:0]   inst_rdata,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [LEN_DATA/8-1:0] data_wstrb,
  input  logic [LEN_ADDR-1:0]   data_addr,
  input  logic [LEN_DATA-1:0]   data_wdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [LEN_DATA-1:0]   data_rdata,
  output logic                  ram_en,
  output logic [LEN_DATA/8-1:0] ram_we,
  output logic [LEN_ADDR-1:0]   ram_addr,
  output logic [LEN_DATA-1:0]   ram_din,
  input  logic [LEN_DATA-1:0]   ram_dout
);

  logic [1:0] req;
  logic [1:0] grant;
  sram_req_t  inst_q;
  sram_req_t  data_q;
  sram_req_t  sel;
  logic       resp_valid;
  port_e      resp_owner;

  // Requests are masked in reset so nothing is granted there.
  assign req = {data_req, inst_req} & {2{resetn}};

  arb_rr2 u_arb (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .advance (|grant),
    .grant   (grant)
  );

  assign inst_q = '{
    wr:    inst_wr,
    wstrb: inst_wstrb,
    addr:  inst_addr,
    wdata: inst_wdata
  };

  assign data_q = '{
    wr:    data_wr,
    wstrb: data_wstrb,
    addr:  data_addr,
    wdata: data_wdata
  };

  // Steer the granted request to the SRAM; idle drives zeros.
  always_comb begin
    sel = '0;
    unique case (1'b1)
      grant[0]: sel = inst_q;
      grant[1]: sel = data_q;
      default:  sel = '0;
    endcase
  end

  assign ram_en       = |grant;
  assign ram_we       = sel.wr ? sel.wstrb : '0;
  assign ram_addr     = sel.addr;
  assign ram_din      = sel.wdata;
  assign inst_addr_ok = grant[0];
  assign data_addr_ok = grant[1];

  // Track who owns the SRAM output in the next cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      resp_valid <= 1'b0;
      resp_owner <= PORT_INST;
    end else begin
      resp_valid <= |grant;
      if (|grant) begin
        resp_owner <= port_e'(grant[1]);
      end
    end
  end

  assign inst_data_ok = resetn && resp_valid
                     && (resp_owner == PORT_INST);
  assign data_data_ok = resetn && resp_valid
                     && (resp_owner == PORT_DATA);
  assign inst_rdata   = inst_data_ok ? ram_dout : '0;
  assign data_rdata   = data_data_ok ? ram_dout : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, grant model
// and a response scoreboard keyed by due cycle.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_din, ram_dout;

  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];

  typedef struct {
    int          due;
    logic        port;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [1:0]  mon_want;
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  logic        m_last = 1'b1;
  logic [1:0]  exp_g;
  logic [3:0]  exp_we;
  logic [31:0] exp_addr;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sram_arbiter dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_wstrb   (inst_wstrb),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout)
  );

  // Read-first, byte-writable SRAM with registered output.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_val;
    end else if (ram_en) begin
      ram_dout <= mem[ram_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (ram_we[b])
          mem[ram_addr[9:2]][8*b +: 8] <= ram_din[8*b +: 8];
    end
  end

  // Response checker: pops the scoreboard when a response is due.
  always @(negedge clk) begin
    if (!resetn) begin
      checks++;
      if (inst_data_ok || data_data_ok) begin
        fails++;
        $display("FAIL data_ok_in_reset: got %b%b want 00",
                 data_data_ok, inst_data_ok);
      end
      sb.delete();
    end else if (sb.size() != 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      mon_want = mon_e.port ? 2'b10 : 2'b01;
      checks++;
      if ({data_data_ok, inst_data_ok} !== mon_want
          || (mon_e.port ? data_rdata : inst_rdata) !== mon_e.rdata
          || (mon_e.port ? inst_rdata : data_rdata) !== 32'h0) begin
        fails++;
        $display("FAIL resp@%0d: ok=%b%b i=%h d=%h want ok=%b rd=%h",
                 cyc, data_data_ok, inst_data_ok, inst_rdata,
                 data_rdata, mon_want, mon_e.rdata);
      end
    end else begin
      checks++;
      if (inst_data_ok || data_data_ok) begin
        fails++;
        $display("FAIL spurious_data_ok@%0d: got %b%b want 00",
                 cyc, data_data_ok, inst_data_ok);
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    pl_en = 1'b1;
    pl_idx = 8'(idx);
    pl_val = v;
    ref_mem[idx] = v;
    next();
    pl_en = 1'b0;
  endtask

  // Predict this cycle's grant, queue its response, go to negedge.
  task automatic cycle();
    logic [1:0]  g;
    logic        w;
    logic [3:0]  s;
    logic [31:0] a, wd;
    int          idx;
    exp_t        e;
    g = 2'b00;
    if (resetn) begin
      if (inst_req && data_req) g = m_last ? 2'b01 : 2'b10;
      else g = {data_req, inst_req};
    end
    exp_g = g;
    exp_we = 4'h0;
    exp_addr = 32'h0;
    if (g != 2'b00) begin
      if (g[0]) {w, s, a, wd} = {inst_wr, inst_wstrb, inst_addr, inst_wdata};
      else {w, s, a, wd} = {data_wr, data_wstrb, data_addr, data_wdata};
      idx = int'(a[9:2]);
      e.due = cyc + 1;
      e.port = g[1];
      e.rdata = ref_mem[idx];
      sb.push_back(e);
      if (w)
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      m_last = g[1];
      exp_we = w ? s : 4'h0;
      exp_addr = a;
    end
    if (!resetn) m_last = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    inst_req = 1'b0;
    data_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      cycle();
      next();
    end
  endtask

  task automatic test_reset();
    inst_req = 1'b1; inst_wr = 1'b0; inst_addr = 32'h0;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h4;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({data_addr_ok, inst_addr_ok, ram_en, ram_we} !== 7'b0) begin
        fails++;
        $display("FAIL reset_outputs: aok=%b%b en=%b we=%b want 0",
                 data_addr_ok, inst_addr_ok, ram_en, ram_we);
      end
      next();
    end
    resetn = 1'b1;
    cycle();
    checks++;
    if ({data_addr_ok, inst_addr_ok} !== 2'b01 || ram_addr !== 32'h0) begin
      fails++;
      $display("FAIL first_tie: aok=%b%b addr=%h want 01 addr=0",
               data_addr_ok, inst_addr_ok, ram_addr);
    end
    next();
    idle(2);
  endtask

  task automatic test_single_read();
    preload(8'h10, 32'hDEADBEEF);
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h40;
    cycle();
    checks++;
    if ({data_addr_ok, inst_addr_ok} !== 2'b10 || ram_addr !== 32'h40
        || ram_en !== 1'b1 || ram_we !== 4'h0) begin
      fails++;
      $display("FAIL single_read_grant: aok=%b%b addr=%h we=%b",
               data_addr_ok, inst_addr_ok, ram_addr, ram_we);
    end
    next();
    data_req = 1'b0;
    cycle();
    checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL single_read_data: ok=%b rd=%h want 1 deadbeef",
               data_data_ok, data_rdata);
    end
    next();
    idle(1);
  endtask

  task automatic test_tie();
    int ni = 0;
    int nd = 0;
    logic [1:0] want;
    inst_req = 1'b1; inst_wr = 1'b0;
    data_req = 1'b1; data_wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      inst_addr = 32'h100 + 32'(4 * ni);
      data_addr = 32'h200 + 32'(4 * nd);
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      cycle();
      checks++;
      if ({data_addr_ok, inst_addr_ok} !== want
          || {data_addr_ok, inst_addr_ok} !== exp_g
          || ram_addr !== exp_addr) begin
        fails++;
        $display("FAIL tie_grant[%0d]: aok=%b%b addr=%h want %b %h",
                 i, data_addr_ok, inst_addr_ok, ram_addr, want, exp_addr);
      end
      if (inst_addr_ok) ni++;
      if (data_addr_ok) nd++;
      next();
    end
    idle(2);
  endtask

  task automatic test_byte_write();
    preload(2, 32'h11223344);
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8;
    data_wstrb = 4'b0010; data_wdata = 32'h0000AB00;
    cycle();
    checks++;
    if (data_addr_ok !== 1'b1 || ram_we !== 4'b0010
        || ram_din !== 32'h0000AB00) begin
      fails++;
      $display("FAIL byte_write: aok=%b we=%b din=%h want 1 0010 0000ab00",
               data_addr_ok, ram_we, ram_din);
    end
    next();
    data_wr = 1'b0;
    cycle();
    next();
    data_req = 1'b0;
    cycle();
    checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'h1122AB44) begin
      fails++;
      $display("FAIL byte_merge: ok=%b rd=%h want 1 1122ab44",
               data_data_ok, data_rdata);
    end
    next();
    data_req = 1'b1; data_wr = 1'b1;
    data_wstrb = 4'b0000; data_wdata = 32'hFFFFFFFF;
    cycle();
    checks++;
    if (ram_en !== 1'b1 || ram_we !== 4'b0000 || data_addr_ok !== 1'b1) begin
      fails++;
      $display("FAIL zero_strobe: en=%b we=%b aok=%b want 1 0000 1",
               ram_en, ram_we, data_addr_ok);
    end
    next();
    data_wr = 1'b0;
    cycle();
    next();
    idle(2);
  endtask

  task automatic test_stream();
    inst_req = 1'b1; inst_wr = 1'b0;
    data_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      inst_addr = 32'h300 + 32'(4 * i);
      cycle();
      checks++;
      if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0
          || ram_addr !== inst_addr) begin
        fails++;
        $display("FAIL stream[%0d]: aok=%b%b addr=%h want 01 %h",
                 i, data_addr_ok, inst_addr_ok, ram_addr, inst_addr);
      end
      next();
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    inst_req = 1'b1; inst_wr = 1'b0; inst_addr = 32'h40;
    cycle();
    checks++;
    if (inst_addr_ok !== 1'b1) begin
      fails++;
      $display("FAIL mid_grant: aok=%b want 1", inst_addr_ok);
    end
    next();
    inst_req = 1'b0;
    resetn = 1'b0;
    cycle();
    checks++;
    if (inst_data_ok !== 1'b0 || inst_rdata !== 32'h0) begin
      fails++;
      $display("FAIL mid_reset_drop: ok=%b rd=%h want 0 0",
               inst_data_ok, inst_rdata);
    end
    next();
    resetn = 1'b1;
    idle(2);
    inst_req = 1'b1; inst_addr = 32'h44;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h48;
    cycle();
    checks++;
    if ({data_addr_ok, inst_addr_ok} !== 2'b01) begin
      fails++;
      $display("FAIL post_reset_tie: aok=%b%b want 01",
               data_addr_ok, inst_addr_ok);
    end
    next();
    idle(2);
  endtask

  initial begin
    resetn = 1'b0;
    pl_en = 1'b0; pl_idx = 8'h0; pl_val = 32'h0;
    inst_req = 1'b0; inst_wr = 1'b0; inst_wstrb = 4'h0;
    inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    next();
    for (int i = 0; i < 256; i++)
      preload(i, 32'hA5000000 ^ (32'(i) * 32'h00010203));
    test_reset();
    test_single_read();
    test_tie();
    test_byte_write();
    test_stream();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d responses outstanding, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one single-port, byte-writable, read-first block SRAM (1-cycle registered read) between the CPU instruction-fetch port and the data port in the SoC_Sram build.
- Each requester speaks the SRAM-like req/addr_ok/data_ok handshake.
- Grants at most one request per cycle using 2-way round-robin, and drives the SRAM enable/address/write-strobe.
- Routes the read data back to the granted requester exactly one cycle later; back-to-back grants are fully pipelined.

Parameters:
- LEN_ADDR, 32, byte-address width of requesters and SRAM.
- LEN_DATA, 32, data width; strobe width is LEN_DATA/8.

Ports:
- clk  in  1  system clock, all logic on posedge.
- resetn  in  1  synchronous, active-low reset.
- inst_req  in  1  instruction-port request valid.
- inst_wr  in  1  1 = write, 0 = read.
- inst_wstrb  in  LEN_DATA/8  byte write enables; ignored when inst_wr=0.
- inst_addr  in  LEN_ADDR  byte address.
- inst_wdata  in  LEN_DATA  write data.
- inst_addr_ok  out  1  request accepted this cycle (combinational).
- inst_data_ok  out  1  response valid (registered).
- inst_rdata  out  LEN_DATA  read data, valid while inst_data_ok=1.
- data_req, data_wr, data_wstrb, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata: same as inst_* for the data port.
- ram_en  out  1  SRAM enable.
- ram_we  out  LEN_DATA/8  SRAM byte write enables.
- ram_addr  out  LEN_ADDR  SRAM byte address (passed through unmodified).
- ram_din  out  LEN_DATA  SRAM write data.
- ram_dout  in  LEN_DATA  SRAM registered read data.

Behaviour:
- State:
  - last_grant: 1 bit, INST/DATA.
  - resp_valid: 1 bit.
  - resp_owner: 1 bit.
- Reset (resetn=0 at posedge): last_grant=DATA (so INST wins the first tie), resp_valid=0, resp_owner=INST.
- While resetn=0, all outputs are 0: ram_en, ram_we, addr_ok, data_ok.
- Arbitration (combinational, each cycle):
  - Only inst_req: grant INST.
  - Only data_req: grant DATA.
  - Both: grant the port != last_grant.
  - Neither: no grant.
- Grant outputs:
  - On grant to P: P_addr_ok=1 and the other port's addr_ok=0.
  - ram_en=1, ram_addr=P_addr, ram_din=P_wdata.
  - ram_we = P_wr ? P_wstrb : 0.
- No grant: ram_en=0, ram_we=0, ram_addr/ram_din=0.
- At posedge with a grant: last_grant<=P, resp_valid<=1, resp_owner<=P. With no grant: resp_valid<=0 and last_grant is held.
- Response cycle (cycle after grant): resp_owner's data_ok=1 for exactly 1 cycle.
  - rdata = ram_dout.
  - Writes also get a data_ok pulse; rdata then returns old contents (read-first), and requesters ignore it.
  - Non-owner rdata=0.
- Latency: addr_ok in cycle N implies data_ok in cycle N+1. Throughput is 1 grant per cycle; responses return in grant order.
- Requesters hold req/wr/addr/wdata/wstrb stable until addr_ok. A request is accepted once per addr_ok cycle.
- Requesters always accept data_ok; there is no backpressure on responses.
- Same-address write then read on consecutive grants: the read returns the new data (the write commits at posedge N, the read at N+1 sees it).
- Simultaneous read+write to the same word in one cycle is impossible (one grant per cycle).
- Starvation bound: a continuously asserted request is granted within 2 cycles.
- Reset mid-operation: any pending response is dropped, no data_ok after reset deasserts, and arbitration restarts at the reset priority.
- wstrb=0 with wr=1: granted as a normal access with ram_we=0; data_ok still pulses.

Decomposition:
- Package sram_arb_pkg:
  - typedef enum logic {PORT_INST=1'b0, PORT_DATA=1'b1} port_e.
  - struct sram_req_t {wr, wstrb, addr, wdata}.
  - Constant STRB_W = LEN_DATA/8.
- One sub-module, arb_rr2: 2-requester round-robin.
  - Inputs: clk, resetn, req[1:0], advance.
  - Outputs: one-hot grant[1:0].
  - Owns last_grant.
  - Reused later for the AXI bridge.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with both reqs=1 -> all addr_ok/data_ok/ram_en=0. After release, first tie grants INST.
- Single read: preload word 0x10=0xDEADBEEF, data_req read addr 0x40 -> data_addr_ok in cycle N, data_data_ok=1 with rdata=0xDEADBEEF in N+1 only.
- Tie alternation: both reqs held 6 cycles with distinct addrs -> grants INST,DATA,INST,DATA,INST,DATA. Each data_ok is routed to the matching owner 1 cycle later with correct rdata.
- Byte write then read: data write addr 0x8, wstrb=4'b0010, wdata=0x0000AB00 over old 0x11223344, then a read in the next grant -> rdata=0x1122AB44.
- Lone requester streaming: inst_req high with 8 addresses, data_req=0 -> addr_ok every cycle and 8 consecutive data_ok pulses in order.
- Reset mid-op: grant in N, resetn=0 in N+1 -> no data_ok in N+1 or later until a new grant.
